// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MAX_N = 16;
  localparam int BEAT_W    = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set request scanning upward from last+1, modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester accepted-word counters (wr_count).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  output logic [N-1:0]       ack,
  output logic [N-1:0]       grant,
  output logic               busy,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [WIDTH-1:0]   fifo_data
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N*CNT_W-1:0] wr_count
`endif
);
  localparam int IDX_W = $clog2(N);
  localparam logic [BEAT_W-1:0] BURST_B  = BEAT_W'(BURST);
  localparam logic [BEAT_W-1:0] BURST_M1 = BEAT_W'(BURST - 1);

  if (N < 2 || N > ARB_MAX_N || CNT_W < 1) begin : g_bad_param
    logic param_error_flag;
    assign param_error_flag = 1'b1;
  end

  arb_state_e        state_reg, state_next;
  logic [N-1:0]      grant_reg, grant_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic [N-1:0]      pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic              owner_req;
  logic [WIDTH-1:0]  masked_data [N];

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
    .req        (req),
    .last       (last_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // One-hot grant lets the data mux be a plain AND-OR with no owner index.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign masked_data[gi] = data[gi*WIDTH +: WIDTH] & {WIDTH{grant_reg[gi]}};
  end

  assign owner_req = |(req & grant_reg);
  assign grant     = grant_reg;
  assign busy      = (state_reg == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      last_reg     <= IDX_W'(N - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      last_reg     <= last_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    last_next     = last_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next    = GRANT;
          grant_next    = pick_onehot;
          last_next     = pick_idx;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (|ack && beat_cnt_reg < BURST_B)
          beat_cnt_next = beat_cnt_reg + 1'b1;
        if (!owner_req || (|ack && beat_cnt_reg == BURST_M1)) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_comb begin
    ack        = '0;
    fifo_data  = '0;
    if (state_reg == GRANT) begin
      ack = grant_reg & req & {N{~fifo_full}};
      for (int i = 0; i < N; i++)
        fifo_data = fifo_data | masked_data[i];
    end
    fifo_write = |ack;
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < N; gi++) begin : g_stats
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt_reg <= '0;
      else if (ack[gi])
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
    assign wr_count[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, WIDTH=8, BURST=4); stats checks only with FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        fifo_full;
  logic        fifo_write;
  logic [7:0]  fifo_data;
`ifdef FIFO_ARB_STATS_EN
  logic [63:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;
  int rem [4];
  int ptr [4];
  logic [7:0] q [$];
  logic [3:0] ack_s;

  fifo_wr_arbiter #(.N(4), .WIDTH(8), .BURST(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .grant      (grant),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_write (fifo_write),
    .fifo_data  (fifo_data)
`ifdef FIFO_ARB_STATS_EN
    ,
    .wr_count   (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Requester i, word j is 0x(8+i)j: requester 2 sends A0, A1, ...
  function automatic logic [7:0] word(int i, int j);
    return 8'((((i + 8) << 4) | j) & 255);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req[i] = (rem[i] > 0);
      data[i*8 +: 8] = word(i, ptr[i]);
    end
  endtask

  // Advance one clock; producers step their word on an ack, FIFO model captures writes.
  task automatic tick();
    ack_s = ack;
    if (fifo_write) q.push_back(fifo_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (ack_s[i]) begin
        rem[i]--;
        ptr[i]++;
      end
    apply();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      ptr[i] = 0;
    end
    apply();
    #3;
    rst_n = 1'b1;
    tick();
    q.delete();
  endtask

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      ptr[i] = 0;
    end
    apply();
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fifo_write", 32'(fifo_write), 32'h0);
    chk("rst_fifo_data", 32'(fifo_data), 32'h0);
    #1;
    rst_n = 1'b1;

    // Single requester: 6 words, burst of 4, bubble, burst of 2
    rem[2] = 6;
    apply();
    #1;
    chk("single_idle_grant", 32'(grant), 32'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("single_grant", 32'(grant), 32'h4);
      chk("single_ack", 32'(ack), 32'h4);
      chk("single_data", 32'(fifo_data), 32'(8'hA0 + 8'(b)));
      tick();
    end
    chk("single_bubble_grant", 32'(grant), 32'h0);
    chk("single_bubble_ack", 32'(ack), 32'h0);
    chk("single_bubble_busy", 32'(busy), 32'h0);
    tick();
    chk("single_regrant", 32'(grant), 32'h4);
    chk("single_data4", 32'(fifo_data), 32'hA4);
    tick();
    chk("single_data5", 32'(fifo_data), 32'hA5);
    chk("single_ack5", 32'(ack), 32'h4);
    tick();
    chk("single_drop_grant", 32'(grant), 32'h4);
    chk("single_drop_ack", 32'(ack), 32'h0);
    tick();
    chk("single_end_busy", 32'(busy), 32'h0);
    chk("single_fifo_len", 32'(q.size()), 32'd6);
    for (int i = 0; i < 6 && i < q.size(); i++)
      chk("single_fifo_word", 32'(q[i]), 32'(8'hA0 + 8'(i)));

    // All requesting: order 0,1,2,3,0 with one bubble per release
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 100;
    apply();
    #1;
    tick();
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 4; b++) begin
        chk("all_grant", 32'(grant), 32'(1 << seq[r]));
        chk("all_ack", 32'(ack), 32'(1 << seq[r]));
        chk("all_data", 32'(fifo_data), 32'(word(seq[r], (r == 4 ? 4 : 0) + b)));
        tick();
      end
      chk("all_bubble_grant", 32'(grant), 32'h0);
      chk("all_bubble_ack", 32'(ack), 32'h0);
      tick();
    end

    // Full stall after 2 acks to requester 1
    do_reset();
    rem[1] = 4;
    apply();
    #1;
    tick();
    chk("stall_grant", 32'(grant), 32'h2);
    chk("stall_data0", 32'(fifo_data), 32'h90);
    tick();
    chk("stall_data1", 32'(fifo_data), 32'h91);
    tick();
    fifo_full = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_write", 32'(fifo_write), 32'h0);
      chk("stall_ack", 32'(ack), 32'h0);
      chk("stall_grant_held", 32'(grant), 32'h2);
      chk("stall_beat_cnt", 32'(dut.beat_cnt_reg), 32'd2);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    chk("stall_resume_ack", 32'(ack), 32'h2);
    chk("stall_data2", 32'(fifo_data), 32'h92);
    tick();
    chk("stall_data3", 32'(fifo_data), 32'h93);
    tick();
    chk("stall_end_grant", 32'(grant), 32'h0);
    chk("stall_fifo_len", 32'(q.size()), 32'd4);

    // Early release by requester 3, then 0 wins over 3
    rem[3] = 1;
    apply();
    #1;
    tick();
    chk("early_grant", 32'(grant), 32'h8);
    chk("early_data", 32'(fifo_data), 32'hB0);
    rem[0] = 5;
    apply();
    #1;
    chk("early_no_preempt", 32'(ack), 32'h8);
    tick();
    chk("early_drop_grant", 32'(grant), 32'h8);
    chk("early_drop_write", 32'(fifo_write), 32'h0);
    tick();
    chk("early_idle_busy", 32'(busy), 32'h0);
    rem[3] = 3;
    apply();
    #1;
    tick();
    chk("early_next_winner", 32'(grant), 32'h1);

    // Reset during the third beat
    do_reset();
    rem[1] = 10;
    apply();
    #1;
    tick();
    tick();
    tick();
    chk("rstmid_ack_before", 32'(ack), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ack", 32'(ack), 32'h0);
    chk("rstmid_write", 32'(fifo_write), 32'h0);
    chk("rstmid_grant", 32'(grant), 32'h0);
    rem[0] = 2;
    apply();
    #2;
    rst_n = 1'b1;
    tick();
    chk("rstmid_first_grant", 32'(grant), 32'h1);

`ifdef FIFO_ARB_STATS_EN
    do_reset();
    rem[0] = 10;
    rem[2] = 3;
    apply();
    #1;
    repeat (30) tick();
    chk("stats_cnt0", 32'(wr_count[15:0]), 32'd10);
    chk("stats_cnt1", 32'(wr_count[31:16]), 32'd0);
    chk("stats_cnt2", 32'(wr_count[47:32]), 32'd3);
    chk("stats_cnt3", 32'(wr_count[63:48]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
